// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the accumulator-CPU control unit.
// Optional single-step support is enabled with CTRL_SINGLE_STEP_EN (see ctrl_fsm).
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_LOADIR,
    S_EXEC,
    S_OPLD,
    S_MEMA,
    S_MEMD,
    S_HALT
  } state_t;

  // What EXEC leads to; OPLD reuses the same class to tell LDM from JMP.
  typedef enum logic [1:0] {
    NX_FETCH,
    NX_LDM,
    NX_JMP,
    NX_HALT
  } next_cls_t;

  localparam logic [1:0] GRP_MISC = 2'b00;
  localparam logic [1:0] GRP_ALU  = 2'b01;
  localparam logic [1:0] GRP_BZF  = 2'b10;
  localparam logic [1:0] GRP_BNZB = 2'b11;

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_LDM  = 3'b010;
  localparam logic [2:0] OP_IN   = 3'b011;
  localparam logic [2:0] OP_OUT  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_SHF  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] JMP_INC  = 2'b00;
  localparam logic [1:0] JMP_ABS  = 2'b01;
  localparam logic [1:0] JMP_BACK = 2'b10;
  localparam logic [1:0] JMP_FWD  = 2'b11;

  localparam logic [1:0] ASEL_SHF = 2'b00;
  localparam logic [1:0] ASEL_RF  = 2'b01;
  localparam logic [1:0] ASEL_IN  = 2'b10;
  localparam logic [1:0] ASEL_MEM = 2'b11;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [1:0] SHF_NONE = 2'b00;

  typedef struct packed {
    logic       ir_load;
    logic [1:0] jmp_sel;
    logic       pc_load;
    logic       mem_inst;
    logic       mr_load;
    logic [1:0] a_sel;
    logic       a_load;
    logic       rf_wr;
    logic [2:0] alu_sel;
    logic [1:0] shift_sel;
    logic       out_en;
    logic       halted;
  } strobes_t;

  localparam strobes_t STROBES_IDLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: IR + accumulator -> EXEC-cycle strobes and
// the class of state that follows EXEC.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] acc,
  output strobes_t          strobes,
  output next_cls_t         next_cls
);

  logic [1:0] grp;
  logic [2:0] fld;
  logic       acc_zero;
  logic       unused_bits;

  // Opcode group sits directly above the offset field.
  assign grp         = instr[ADDR_W +: 2];
  assign fld         = instr[ADDR_W-1 -: 3];
  assign acc_zero    = (acc == '0);
  assign unused_bits = instr[2];

  always_comb begin
    strobes  = STROBES_IDLE;
    next_cls = NX_FETCH;
    case (grp)
      GRP_MISC: begin
        case (fld)
          OP_LDA: begin
            strobes.a_sel  = ASEL_RF;
            strobes.a_load = 1'b1;
          end
          OP_STA:  strobes.rf_wr = 1'b1;
          OP_LDM:  next_cls = NX_LDM;
          OP_IN: begin
            strobes.a_sel  = ASEL_IN;
            strobes.a_load = 1'b1;
          end
          OP_OUT:  strobes.out_en = 1'b1;
          OP_JMP:  next_cls = NX_JMP;
          OP_SHF: begin
            strobes.alu_sel   = ALU_PASS;
            strobes.shift_sel = instr[1:0];
            strobes.a_sel     = ASEL_SHF;
            strobes.a_load    = 1'b1;
          end
          OP_HALT: next_cls = NX_HALT;
        endcase
      end
      GRP_ALU: begin
        strobes.alu_sel   = fld;
        strobes.shift_sel = SHF_NONE;
        strobes.a_sel     = ASEL_SHF;
        strobes.a_load    = 1'b1;
      end
      GRP_BZF: begin
        if (acc_zero) begin
          strobes.pc_load = 1'b1;
          strobes.jmp_sel = JMP_FWD;
        end
      end
      GRP_BNZB: begin
        if (!acc_zero) begin
          strobes.pc_load = 1'b1;
          strobes.jmp_sel = JMP_BACK;
        end
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM for the 8-bit accumulator datapath.
// Define CTRL_SINGLE_STEP_EN to add the 'step' input that gates FETCH.
module ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [DATA_W-1:0] INSTR,
  input  logic [DATA_W-1:0] accout,
  output logic              IRload,
  output logic [1:0]        Jmpmuxsel,
  output logic              PCload,
  output logic              MemInst,
  output logic              MRload,
  output logic [1:0]        Asel,
  output logic              Aload,
  output logic              RFwr,
  output logic [2:0]        ALUsel,
  output logic [1:0]        Shiftsel,
  output logic              outen,
  output logic              halted
);

  state_t    state;
  state_t    state_nx;
  strobes_t  dec_strb;
  next_cls_t dec_cls;
  strobes_t  strb;
  logic      step_go;

`ifdef CTRL_SINGLE_STEP_EN
  assign step_go = step;
`else
  assign step_go = 1'b1;
`endif

  ctrl_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .instr    (INSTR),
    .acc      (accout),
    .strobes  (dec_strb),
    .next_cls (dec_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    strb     = STROBES_IDLE;
    case (state)
      S_FETCH: begin
        if (step_go) state_nx = S_LOADIR;
      end
      S_LOADIR: begin
        strb.ir_load = 1'b1;
        strb.pc_load = 1'b1;
        strb.jmp_sel = JMP_INC;
        state_nx     = S_EXEC;
      end
      S_EXEC: begin
        strb = dec_strb;
        case (dec_cls)
          NX_LDM, NX_JMP: state_nx = S_OPLD;
          NX_HALT:        state_nx = S_HALT;
          default:        state_nx = S_FETCH;
        endcase
      end
      // IR still holds the opcode here, so the decode class picks LDM vs JMP.
      S_OPLD: begin
        strb.pc_load = 1'b1;
        if (dec_cls == NX_LDM) begin
          strb.mr_load = 1'b1;
          strb.jmp_sel = JMP_INC;
          state_nx     = S_MEMA;
        end else begin
          strb.jmp_sel = JMP_ABS;
          state_nx     = S_FETCH;
        end
      end
      S_MEMA: begin
        strb.mem_inst = 1'b1;
        state_nx      = S_MEMD;
      end
      S_MEMD: begin
        strb.mem_inst = 1'b1;
        strb.a_sel    = ASEL_MEM;
        strb.a_load   = 1'b1;
        state_nx      = S_FETCH;
      end
      S_HALT: begin
        strb.halted = 1'b1;
      end
      default: state_nx = S_FETCH;
    endcase
    // Outputs are forced quiet for the whole reset cycle, whatever the state.
    if (reset) strb = STROBES_IDLE;
  end

  assign IRload    = strb.ir_load;
  assign Jmpmuxsel = strb.jmp_sel;
  assign PCload    = strb.pc_load;
  assign MemInst   = strb.mem_inst;
  assign MRload    = strb.mr_load;
  assign Asel      = strb.a_sel;
  assign Aload     = strb.a_load;
  assign RFwr      = strb.rf_wr;
  assign ALUsel    = strb.alu_sel;
  assign Shiftsel  = strb.shift_sel;
  assign outen     = strb.out_en;
  assign halted    = strb.halted;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench: ctrl_fsm driving a small accumulator datapath with a 64x8 synchronous RAM,
// checked every cycle against an instruction-level reference model.
`timescale 1ns/1ps
module tb_ctrl_fsm;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic step = 1'b1;
  logic [7:0] in_port = 8'h00;
  logic [7:0] in_val = 8'h00;
  logic in_fixed = 1'b1;

  logic IRload, PCload, MemInst, MRload, Aload, RFwr, outen, halted;
  logic [1:0] Jmpmuxsel, Asel, Shiftsel;
  logic [2:0] ALUsel;

  // datapath state
  logic [7:0] ir, acc, rd, outr, ma8;
  logic [5:0] pc;
  logic [7:0] rf [8];
  logic [7:0] mem [64];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
`ifdef CTRL_SINGLE_STEP_EN
    .step(step),
`endif
    .INSTR(ir), .accout(acc),
    .IRload(IRload), .Jmpmuxsel(Jmpmuxsel), .PCload(PCload), .MemInst(MemInst),
    .MRload(MRload), .Asel(Asel), .Aload(Aload), .RFwr(RFwr), .ALUsel(ALUsel),
    .Shiftsel(Shiftsel), .outen(outen), .halted(halted)
  );

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a;
      3'd1: return a + b;
      3'd2: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return ~a;
      default: return a + 8'd1;
    endcase
  endfunction

  function automatic logic [7:0] shf_f(input logic [1:0] s, input logic [7:0] x);
    case (s)
      2'd0: return x;
      2'd1: return {x[6:0], 1'b0};
      2'd2: return {1'b0, x[7:1]};
      default: return {x[6:0], x[7]};
    endcase
  endfunction

  always @(posedge clk) begin
    rd <= mem[MemInst ? ma8[5:0] : pc];
    if (reset) begin
      pc <= 6'd0; ir <= 8'h00; ma8 <= 8'h00; acc <= 8'h00; outr <= 8'h00;
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    end else begin
      if (IRload) ir <= rd;
      if (PCload) begin
        case (Jmpmuxsel)
          2'b00: pc <= pc + 6'd1;
          2'b01: pc <= rd[5:0];
          2'b10: pc <= pc - ir[5:0];
          default: pc <= pc + ir[5:0];
        endcase
      end
      if (MRload) ma8 <= {2'b00, rd[5:0]};
      if (Aload) begin
        case (Asel)
          2'b00: acc <= shf_f(Shiftsel, alu_f(ALUsel, acc, rf[ir[2:0]]));
          2'b01: acc <= rf[ir[2:0]];
          2'b10: acc <= in_port;
          default: acc <= rd;
        endcase
      end
      if (RFwr) rf[ir[2:0]] <= acc;
      if (outen) outr <= acc;
    end
  end

  // Output vector layout: {IRload, Jmpmuxsel, PCload, MemInst, MRload, Asel, Aload, RFwr, ALUsel, Shiftsel, outen, halted}
  logic [16:0] dut_vec;
  assign dut_vec = {IRload, Jmpmuxsel, PCload, MemInst, MRload, Asel, Aload, RFwr, ALUsel, Shiftsel, outen, halted};

  localparam logic [16:0] V_IDLE   = 17'd0;
  localparam logic [16:0] V_LOADIR = {1'b1, 2'b00, 1'b1, 13'd0};
  localparam logic [16:0] V_RFWR   = 17'd1 << 7;
  localparam logic [16:0] V_OUT    = 17'd1 << 1;
  localparam logic [16:0] V_HALT   = 17'd1;
  localparam logic [16:0] V_MEMA   = 17'd1 << 12;
  localparam logic [16:0] V_LDMOP  = {1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 11'd0};

  function automatic logic [16:0] v_pc(input logic [1:0] js);
    return {1'b0, js, 1'b1, 13'd0};
  endfunction

  function automatic logic [16:0] v_a(input logic [1:0] as, input logic [2:0] alu, input logic [1:0] sh);
    return {4'd0, 2'd0, as, 1'b1, 1'b0, alu, sh, 2'd0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: architectural state plus queue of expected per-cycle outputs
  logic [5:0]  m_pc;
  logic [7:0]  m_acc, m_out;
  logic [7:0]  m_rf [8];
  logic        m_halted;
  logic        at_fetch;
  logic [16:0] q [$];

  task automatic model_reset();
    q.delete();
    m_pc = 6'd0; m_acc = 8'h00; m_out = 8'h00; m_halted = 1'b0; at_fetch = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
  endtask

  // Executes one whole instruction at ISA level, queuing the strobes of the cycles after FETCH.
  task automatic model_step();
    logic [7:0] i, opnd;
    logic [5:0] pc1;
    i = mem[m_pc];
    pc1 = m_pc + 6'd1;
    m_pc = pc1;
    q.push_back(V_LOADIR);
    case (i[7:6])
      2'b00: begin
        case (i[5:3])
          3'd0: begin q.push_back(v_a(2'b01, 3'd0, 2'd0)); m_acc = m_rf[i[2:0]]; end
          3'd1: begin q.push_back(V_RFWR); m_rf[i[2:0]] = m_acc; end
          3'd2: begin
            opnd = mem[pc1];
            q.push_back(V_IDLE); q.push_back(V_LDMOP); q.push_back(V_MEMA);
            q.push_back(V_MEMA | v_a(2'b11, 3'd0, 2'd0));
            m_acc = mem[opnd[5:0]];
            m_pc = pc1 + 6'd1;
          end
          3'd3: begin q.push_back(v_a(2'b10, 3'd0, 2'd0)); m_acc = in_port; end
          3'd4: begin q.push_back(V_OUT); m_out = m_acc; end
          3'd5: begin
            opnd = mem[pc1];
            q.push_back(V_IDLE); q.push_back(v_pc(2'b01));
            m_pc = opnd[5:0];
          end
          3'd6: begin q.push_back(v_a(2'b00, 3'd0, i[1:0])); m_acc = shf_f(i[1:0], m_acc); end
          default: begin q.push_back(V_IDLE); m_halted = 1'b1; end
        endcase
      end
      2'b01: begin
        q.push_back(v_a(2'b00, i[5:3], 2'b00));
        m_acc = alu_f(i[5:3], m_acc, m_rf[i[2:0]]);
      end
      2'b10: begin
        if (m_acc == 8'h00) begin q.push_back(v_pc(2'b11)); m_pc = pc1 + i[5:0]; end
        else q.push_back(V_IDLE);
      end
      default: begin
        if (m_acc != 8'h00) begin q.push_back(v_pc(2'b10)); m_pc = pc1 - i[5:0]; end
        else q.push_back(V_IDLE);
      end
    endcase
  endtask

  initial begin : compare
    logic [16:0] exp_v;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_outs", 32'(dut_vec), 32'(V_IDLE));
        model_reset();
      end else if (q.size() == 0 && !at_fetch && m_halted) begin
        check("halt_outs", 32'(dut_vec), 32'(V_HALT));
      end else begin
        if (q.size() == 0 && !at_fetch) begin
          check("arch_pc", 32'(pc), 32'(m_pc));
          check("arch_acc", 32'(acc), 32'(m_acc));
          check("arch_out", 32'(outr), 32'(m_out));
          in_port = in_fixed ? in_val : 8'($urandom);
          model_step();
          at_fetch = 1'b1;
        end
        if (at_fetch) begin
          check("fetch_outs", 32'(dut_vec), 32'(V_IDLE));
          if (step) at_fetch = 1'b0;
        end else begin
          exp_v = q.pop_front();
          check("cycle_outs", 32'(dut_vec), 32'(exp_v));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold reset for one cycle with a zeroed memory; caller fills the program before release.
  task automatic begin_prog(input logic [7:0] inv);
    reset = 1'b1;
    in_fixed = 1'b1;
    in_val = inv;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
  endtask

  task automatic release_rst();
    tick(1);
    reset = 1'b0;
  endtask

  initial begin : main
    tick(2);

    // reset mid-LDM, then LDM run to completion
    begin_prog(8'h00);
    mem[0] = 8'h10; mem[1] = 8'h3F; mem[63] = 8'hC3;
    release_rst();
    tick(4);
    check("ldm_mema_meminst", 32'(MemInst), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_cycle_outs", 32'(dut_vec), 32'd0);
    tick(1);
    reset = 1'b0;
    #1;
    check("after_rst_outs", 32'(dut_vec), 32'd0);
    check("after_rst_pc", 32'(pc), 32'd0);
    tick(1);
    check("after_rst_irload", 32'(IRload), 32'd1);
    tick(5);
    check("ldm_acc", 32'(acc), 32'hC3);
    check("ldm_pc", 32'(pc), 32'd2);

    // IN 5A; OUT
    begin_prog(8'h5A);
    mem[0] = 8'h18; mem[1] = 8'h20;
    release_rst();
    tick(1);
    check("inout_irload_c2", 32'(IRload), 32'd1);
    tick(1);
    check("inout_irload_c3", 32'(IRload), 32'd0);
    tick(2);
    check("inout_irload_c5", 32'(IRload), 32'd1);
    tick(2);
    check("inout_out", 32'(outr), 32'h5A);

    // BZF taken with A=0
    begin_prog(8'h00);
    mem[0] = 8'h28; mem[1] = 8'h0A; mem[10] = 8'h85;
    release_rst();
    tick(7);
    check("bzf_taken_pc", 32'(pc), 32'd16);

    // BZF not taken with A=1
    begin_prog(8'h01);
    mem[0] = 8'h18; mem[1] = 8'h28; mem[2] = 8'h0A; mem[10] = 8'h85;
    release_rst();
    tick(10);
    check("bzf_nt_pc", 32'(pc), 32'd11);
    check("bzf_nt_acc", 32'(acc), 32'd1);

    // BNZB offset 1 loops on itself
    begin_prog(8'h07);
    mem[0] = 8'h18; mem[1] = 8'hC1;
    release_rst();
    tick(6);
    check("bnzb_pc_1", 32'(pc), 32'd1);
    tick(3);
    check("bnzb_pc_2", 32'(pc), 32'd1);
    check("bnzb_ir", 32'(ir), 32'hC1);

    // JMP 3F then HALT at 63 (PC wraps to 0)
    begin_prog(8'h00);
    mem[0] = 8'h28; mem[1] = 8'h3F; mem[63] = 8'h38;
    release_rst();
    tick(7);
    check("halt_set", 32'(halted), 32'd1);
    check("halt_pc_wrap", 32'(pc), 32'd0);
    in_fixed = 1'b0;
    for (int c = 0; c < 20; c++) begin
`ifdef CTRL_SINGLE_STEP_EN
      step = 1'($urandom);
`endif
      tick(1);
    end
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b1;
`endif
    check("halt_stays", 32'(halted), 32'd1);
    reset = 1'b1;
    #1;
    check("halt_rst_cycle", 32'(halted), 32'd0);
    tick(1);
    reset = 1'b0;
    #1;
    check("halt_cleared", 32'(halted), 32'd0);

`ifdef CTRL_SINGLE_STEP_EN
    // single-step: step low holds FETCH, one pulse runs one instruction
    begin_prog(8'h33);
    mem[0] = 8'h18; mem[1] = 8'h20;
    step = 1'b0;
    release_rst();
    tick(10);
    check("step_hold_pc", 32'(pc), 32'd0);
    check("step_hold_outs", 32'(dut_vec), 32'd0);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    tick(5);
    check("step_one_pc", 32'(pc), 32'd1);
    check("step_one_acc", 32'(acc), 32'h33);
    step = 1'b1;
`endif

    // randomized programs
    for (int seg = 0; seg < 12; seg++) begin
      reset = 1'b1;
      in_fixed = 1'b0;
      for (int i = 0; i < 64; i++) begin
        mem[i] = 8'($urandom);
        if (mem[i] >= 8'h38 && mem[i] <= 8'h3F && ($urandom % 8) != 0)
          mem[i] = 8'($urandom_range(0, 55));
      end
      release_rst();
      for (int c = 0; c < 400; c++) begin
`ifdef CTRL_SINGLE_STEP_EN
        step = ($urandom % 3) != 0;
`endif
        reset = ($urandom % 150) == 0;
        tick(1);
      end
      reset = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
      step = 1'b1;
`endif
    end

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
